// File: rtl/reg_bank_arbiter_pkg.sv
// Shared types and port identifiers for the register-bank arbiter.
package reg_bank_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    RDWAIT = 2'd2
  } arb_state_t;

  localparam logic ARB_PORT_DISPATCH = 1'b0;
  localparam logic ARB_PORT_AUX      = 1'b1;

endpackage

// File: rtl/reg_bank_arbiter_rr_pick2.sv
// Two-requester round-robin picker: one-hot grant, the port not granted last wins a tie.
module rr_pick2
  import reg_bank_arbiter_pkg::*;
(
  input  logic       req_0,
  input  logic       req_1,
  input  logic       last_gnt,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = '0;
    if (req_0 && (!req_1 || last_gnt == ARB_PORT_AUX)) begin
      gnt[0] = 1'b1;
    end else if (req_1) begin
      gnt[1] = 1'b1;
    end
  end

endmodule

// File: rtl/reg_bank_arbiter.sv
// Two-port round-robin arbiter and access sequencer in front of register_bank.
module reg_bank_arbiter
  import reg_bank_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_0,
  input  logic              we_0,
  input  logic [ADDR_W-1:0] addr_0,
  input  logic [DATA_W-1:0] wdata_0,
  output logic              gnt_0,
  output logic              done_0,
  output logic [DATA_W-1:0] rdata_0,
  input  logic              req_1,
  input  logic              we_1,
  input  logic [ADDR_W-1:0] addr_1,
  input  logic [DATA_W-1:0] wdata_1,
  output logic              gnt_1,
  output logic              done_1,
  output logic [DATA_W-1:0] rdata_1,
  output logic              reg_write_en,
  output logic              reg_read_en,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_write_data,
  input  logic [DATA_W-1:0] reg_read_data
);

  arb_state_t state;
  logic       last_gnt;
  logic       owner;
  logic       cmd_we;
  logic [2:0] cnt;
  logic [1:0] pick;
  logic       sel_we;

  rr_pick2 u_pick (
    .req_0    (req_0),
    .req_1    (req_1),
    .last_gnt (last_gnt),
    .gnt      (pick)
  );

  assign gnt_0  = (state == IDLE) && pick[0];
  assign gnt_1  = (state == IDLE) && pick[1];
  assign sel_we = gnt_1 ? we_1 : we_0;

  // The winner's command goes straight into the bank-side registers at the
  // grant edge, so address, data and strobe are all valid throughout ISSUE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      last_gnt       <= ARB_PORT_AUX;
      owner          <= ARB_PORT_DISPATCH;
      cmd_we         <= 1'b0;
      cnt            <= '0;
      done_0         <= 1'b0;
      done_1         <= 1'b0;
      rdata_0        <= '0;
      rdata_1        <= '0;
      reg_write_en   <= 1'b0;
      reg_read_en    <= 1'b0;
      reg_addr       <= '0;
      reg_write_data <= '0;
    end else begin
      reg_write_en <= 1'b0;
      reg_read_en  <= 1'b0;
      done_0       <= 1'b0;
      done_1       <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt_0 || gnt_1) begin
            owner          <= gnt_1 ? ARB_PORT_AUX : ARB_PORT_DISPATCH;
            last_gnt       <= gnt_1 ? ARB_PORT_AUX : ARB_PORT_DISPATCH;
            cmd_we         <= sel_we;
            reg_addr       <= gnt_1 ? addr_1 : addr_0;
            reg_write_data <= gnt_1 ? wdata_1 : wdata_0;
            reg_write_en   <= sel_we;
            reg_read_en    <= !sel_we;
            state          <= ISSUE;
          end
        end
        ISSUE: begin
          if (cmd_we) begin
            if (owner == ARB_PORT_AUX) done_1 <= 1'b1;
            else                       done_0 <= 1'b1;
            state <= IDLE;
          end else begin
            cnt   <= 3'(RD_LATENCY);
            state <= RDWAIT;
          end
        end
        RDWAIT: begin
          if (cnt <= 3'd1) begin
            if (owner == ARB_PORT_AUX) begin
              rdata_1 <= reg_read_data;
              done_1  <= 1'b1;
            end else begin
              rdata_0 <= reg_read_data;
              done_0  <= 1'b1;
            end
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/reg_bank_arbiter.md
# reg_bank_arbiter

Two-port round-robin arbiter and access sequencer for `register_bank`. It lets `cmd_dispatcher` (port 0) and one auxiliary requester (port 1, e.g. a status/counter updater) share the single register-bank port. It serializes their accesses, drives the bank's write/read strobes, and returns read data to the owning port. It sits between the requesters and `register_bank`, replacing the direct dispatcher-to-bank connection.

## Interface
Parameters:
- `ADDR_W`, 8, register address width
- `DATA_W`, 8, register data width
- `RD_LATENCY`, 1, cycles from `reg_read_en` to valid `reg_read_data`; legal range 1–4

Ports (`i` = 0, 1):
- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `req_i`  in  1  port i requests an access; held until granted
- `we_i`  in  1  1 = write, 0 = read
- `addr_i`  in  ADDR_W  target address
- `wdata_i`  in  DATA_W  write data
- `gnt_i`  out  1  request accepted this cycle (combinational)
- `done_i`  out  1  one-cycle pulse when port i's access completes
- `rdata_i`  out  DATA_W  read result, valid while `done_i` is high for a read
- `reg_write_en`  out  1  bank write strobe
- `reg_read_en`  out  1  bank read strobe
- `reg_addr`  out  ADDR_W  bank address
- `reg_write_data`  out  DATA_W  bank write data
- `reg_read_data`  in  DATA_W  bank read data

## Operation
- FSM states: IDLE, ISSUE, RDWAIT.
- **IDLE:**
  - If any `req_i` is high, assert `gnt` to exactly one winner in the same cycle.
  - Latch the winner's `we`, `addr`, `wdata` and owner ID at the clock edge, then go to ISSUE.
- **Arbitration:**
  - Only one port requesting: that port wins.
  - Both requesting: the port not granted last wins.
  - The last-grant pointer resets to 1, so port 0 wins the first tie.
- **ISSUE (exactly one cycle):**
  - Drive `reg_addr` and `reg_write_data` from the latched command.
  - Pulse `reg_write_en` if write, else `reg_read_en`.
  - Write: go to IDLE and pulse the owner's `done`.
  - Read: load the latency counter with `RD_LATENCY` and go to RDWAIT.
- **RDWAIT:**
  - Decrement the counter each cycle.
  - In the cycle where the counter reaches 1, register `reg_read_data` into the owner's `rdata`, pulse its `done` next cycle, and go to IDLE.
- A new grant may be issued in the same IDLE cycle in which a `done` is pulsed.
- `gnt` is never asserted outside IDLE. Requests arriving during ISSUE or RDWAIT wait.
- Requester rule: keep `req`, `we`, `addr`, `wdata` stable until the cycle `gnt` is high. In the next cycle, drop `req` or present a new request.
- `rdata_i` holds its last read value until that port's next read completes. Writes do not alter it.
- `reg_addr` and `reg_write_data` hold their last values outside ISSUE. Strobes are 0 outside ISSUE.

## Timing
- Reset values:
  - state IDLE, pointer 1, counter 0
  - all `gnt`, `done`, `reg_write_en`, `reg_read_en` = 0
  - `reg_addr`, `reg_write_data`, `rdata_0`, `rdata_1` = 0
- Write, granted in cycle T: strobe at T+1, `done` at T+2, next grant possible at T+2.
- Read, granted in cycle T: strobe at T+1, `done` with `rdata` at T+2+RD_LATENCY.
- Throughput: one write per 2 cycles; one read per 2+RD_LATENCY cycles.
- Continuous contention alternates strictly: 0, 1, 0, 1 …
- Reset mid-operation: the in-flight access is abandoned. No `done` is pulsed. A strobe already issued is not retracted.

## Structure
- Add to `cmd_pkg`:
  - `arb_state_t` enum (IDLE, ISSUE, RDWAIT)
  - `ARB_PORT_DISPATCH` = 0, `ARB_PORT_AUX` = 1
- Sub-module `rr_pick2` (combinational): inputs two requests and the last-grant pointer; outputs a one-hot grant. It keeps the fairness logic isolated for reuse by other shared resources.
- Integration: the structural command-path wrapper connects `cmd_dispatcher` memory signals to port 0, exposes port 1, and connects the `reg_*` side to `register_bank`.

## Test plan
- Port 0 write addr 0x10, data 0xA5, granted at T: `reg_write_en`=1 at T+1 with `reg_addr`=0x10, `reg_write_data`=0xA5; `done_0` at T+2.
- Port 0 read addr 0x10 after that write (RD_LATENCY=1), granted at T: `reg_read_en` at T+1; `done_0` at T+3 with `rdata_0`=0xA5; `rdata_1` stays 0.
- Both ports request from reset (port 0 write 0x01→0x11, port 1 write 0x02→0x22): grant order is 0 then 1 two cycles apart; the bank then holds 0x11 at 0x01 and 0x22 at 0x02.
- Both ports hold reads continuously for 8 accesses: grants alternate 0, 1, 0, 1 …; each read takes 3 cycles; no overlapping strobes.
- Port 1 requests during port 0's RDWAIT: no `gnt_1` until port 0's `done_0` cycle, then `gnt_1` in that same cycle.
- Assert `rst` in the RDWAIT cycle of a read: no `done` pulse; all outputs at reset values next cycle; a fresh port 0 read then completes normally.
